// File: rtl/tdm_demux4_pkg.sv
// tdm_demux_pkg: shared types and frame geometry for the tdm_demux4 receiver.
// Build option: TDM_DEMUX_PARITY_EN adds a fifth (even parity) slot per frame.
package tdm_demux_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned N_SLOTS = 5;
`else
  localparam int unsigned N_SLOTS = 4;
`endif

  localparam int unsigned SLOT_W = $clog2(N_SLOTS);

endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: slot-serial input and four-channel output bundle.
//   din/en/sync       : slot data, slot strobe, frame marker (source -> demux)
//   a/b/c/d           : channel outputs 0..3 (demux -> consumers)
//   valid             : one-cycle pulse per complete frame
//   locked / sync_err : alignment status / one-cycle alignment error pulse
//   par_err           : parity error pulse, present only with TDM_DEMUX_PARITY_EN
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             en;
  logic             sync;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             valid;
  logic             locked;
  logic             sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic             par_err;

  modport master (
    output din, en, sync,
    input  a, b, c, d, valid, locked, sync_err, par_err
  );
  modport slave (
    input  din, en, sync,
    output a, b, c, d, valid, locked, sync_err, par_err
  );
`else
  modport master (
    output din, en, sync,
    input  a, b, c, d, valid, locked, sync_err
  );
  modport slave (
    input  din, en, sync,
    output a, b, c, d, valid, locked, sync_err
  );
`endif
endinterface

// File: rtl/tdm_demux4_slot_ctr.sv
// tdm_slot_ctr: modulo-N_SLOTS slot counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force slot 0 (highest priority)
//   load1      : force slot 1 (sync accepted as slot 0 this cycle)
//   inc        : advance, wrapping N_SLOTS-1 -> 0
//   slot       : current slot index
//   at_first   : slot == 0
//   at_last    : slot == N_SLOTS-1
module tdm_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              at_first,
  output logic              at_last
);

  assign at_first = (slot == '0);
  assign at_last  = (slot == SLOT_W'(N_SLOTS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= at_last ? '0 : slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive-side 1:4 TDM demultiplexer aligned on a frame-sync marker.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : tdm_demux4_if.slave (din/en/sync in; a..d, valid, locked,
//           sync_err and, with TDM_DEMUX_PARITY_EN, par_err out)
// Build option: TDM_DEMUX_PARITY_EN -> 5-slot frame with even parity in slot 4.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  state_t              state;
  logic [WIDTH-1:0]    stg [N_SLOTS-1];
  logic [WIDTH-1:0]    a_q, b_q, c_q, d_q;
  logic                valid_q, locked_q, sync_err_q;
  logic [SLOT_W-1:0]   slot;
  logic                at_first, at_last;
  logic                ctr_clr, ctr_load1, ctr_inc;
`ifdef TDM_DEMUX_PARITY_EN
  logic                par_err_q;
`endif

  tdm_slot_ctr u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ctr_clr),
    .load1    (ctr_load1),
    .inc      (ctr_inc),
    .slot     (slot),
    .at_first (at_first),
    .at_last  (at_last)
  );

  // Counter steering mirrors the FSM decisions below: a sync at slot 0 is a
  // plain advance, a sync anywhere else realigns to slot 1.
  always_comb begin
    ctr_clr   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_inc   = 1'b0;
    if (bus.en) begin
      if (state == HUNT) begin
        ctr_load1 = bus.sync;
      end else if (at_first) begin
        ctr_inc = bus.sync;
        ctr_clr = !bus.sync;
      end else if (bus.sync) begin
        ctr_load1 = 1'b1;
      end else begin
        ctr_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HUNT;
      for (int unsigned i = 0; i < N_SLOTS - 1; i++) stg[i] <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
      if (bus.en) begin
        case (state)
          HUNT: begin
            if (bus.sync) begin
              stg[0]   <= bus.din;
              state    <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (at_first && !bus.sync) begin
              sync_err_q <= 1'b1;
              state      <= HUNT;
              locked_q   <= 1'b0;
            end else if (!at_first && bus.sync) begin
              // Partial frame is simply overwritten; it never reached a..d.
              sync_err_q <= 1'b1;
              stg[0]     <= bus.din;
            end else if (at_last) begin
              a_q     <= stg[0];
              b_q     <= stg[1];
              c_q     <= stg[2];
              valid_q <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
              d_q       <= stg[3];
              par_err_q <= (stg[0] ^ stg[1] ^ stg[2] ^ stg[3]) != bus.din;
`else
              d_q     <= bus.din;
`endif
            end else begin
              for (int unsigned i = 0; i < N_SLOTS - 1; i++) begin
                if (slot == SLOT_W'(i)) stg[i] <= bus.din;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.a        = a_q;
  assign bus.b        = b_q;
  assign bus.c        = c_q;
  assign bus.d        = d_q;
  assign bus.valid    = valid_q;
  assign bus.locked   = locked_q;
  assign bus.sync_err = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

  localparam int unsigned W = 4;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int NS = 5;
`else
  localparam int NS = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux4_if #(.WIDTH(W)) bus ();
  tdm_demux4 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic         lk;
    logic [W-1:0] a, b, c, d;
  } snap_t;

  typedef struct packed {
    logic         is_err;
    int           cyc;
    logic [W-1:0] a, b, c, d;
    logic         par;
  } ev_t;

  snap_t snapq[$];
  ev_t   evq[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  // Reference model state: lock flag, samples of the frame in progress,
  // and the channel values currently presented.
  bit           m_locked = 1'b0;
  logic [W-1:0] m_frame[$];
  logic [W-1:0] m_out[4] = '{default: '0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s @cycle %0d", name, cyc);
  endtask

  task automatic step(input bit r, input bit e, input bit s, input logic [W-1:0] dv);
    ev_t   ev;
    snap_t sn;
    logic [W-1:0] x;
    @(negedge clk);
    rst_n    = r;
    bus.en   = e;
    bus.sync = s;
    bus.din  = dv;
    ev = '0;
    ev.cyc = cyc + 1;
    if (!r) begin
      m_locked = 1'b0;
      m_frame.delete();
      for (int i = 0; i < 4; i++) m_out[i] = '0;
    end else if (e) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1'b1;
          m_frame.delete();
          m_frame.push_back(dv);
        end
      end else if (m_frame.size() == 0 && !s) begin
        ev.is_err = 1'b1;
        evq.push_back(ev);
        m_locked = 1'b0;
      end else if (m_frame.size() != 0 && s) begin
        ev.is_err = 1'b1;
        evq.push_back(ev);
        m_frame.delete();
        m_frame.push_back(dv);
      end else begin
        m_frame.push_back(dv);
        if (m_frame.size() == NS) begin
          for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
          x = m_frame[0] ^ m_frame[1] ^ m_frame[2] ^ m_frame[3];
          ev.par = (NS == 5) && (x != m_frame[NS-1]);
          ev.a = m_out[0]; ev.b = m_out[1]; ev.c = m_out[2]; ev.d = m_out[3];
          evq.push_back(ev);
          m_frame.delete();
        end
      end
    end
    sn = {m_locked, m_out[0], m_out[1], m_out[2], m_out[3]};
    snapq.push_back(sn);
  endtask

  task automatic slot(input bit s, input logic [W-1:0] dv);
    step(1'b1, 1'b1, s, dv);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, W'($urandom));
  endtask

  // Monitor: per-cycle status snapshot plus event scoreboard for valid/sync_err.
  initial begin
    snap_t sn;
    ev_t   e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (snapq.size() > 0) begin
        sn = snapq.pop_front();
        check("locked", 32'(bus.locked), 32'(sn.lk));
        check("a_hold", 32'(bus.a), 32'(sn.a));
        check("b_hold", 32'(bus.b), 32'(sn.b));
        check("c_hold", 32'(bus.c), 32'(sn.c));
        check("d_hold", 32'(bus.d), 32'(sn.d));
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        flag(e.is_err ? "missing_sync_err" : "missing_valid");
      end
      if (bus.valid === 1'b1) begin
        if (evq.size() > 0 && !evq[0].is_err) begin
          e = evq.pop_front();
          check("valid_time", 32'(cyc), 32'(e.cyc));
          check("frame_a", 32'(bus.a), 32'(e.a));
          check("frame_b", 32'(bus.b), 32'(e.b));
          check("frame_c", 32'(bus.c), 32'(e.c));
          check("frame_d", 32'(bus.d), 32'(e.d));
`ifdef TDM_DEMUX_PARITY_EN
          check("par_err", 32'(bus.par_err), 32'(e.par));
`endif
        end else begin
          flag("unexpected_valid");
        end
      end
`ifdef TDM_DEMUX_PARITY_EN
      if (bus.par_err === 1'b1 && bus.valid !== 1'b1) flag("par_err_without_valid");
`endif
      if (bus.sync_err === 1'b1) begin
        if (evq.size() > 0 && evq[0].is_err) begin
          e = evq.pop_front();
          check("sync_err_time", 32'(cyc), 32'(e.cyc));
        end else begin
          flag("unexpected_sync_err");
        end
      end
    end
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [W-1:0] v0, v1, v2, v3);
    slot(1'b1, v0); slot(1'b0, v1); slot(1'b0, v2); slot(1'b0, v3);
`ifdef TDM_DEMUX_PARITY_EN
    slot(1'b0, v0 ^ v1 ^ v2 ^ v3);
`endif
  endtask

  initial begin
    logic [W-1:0] v[5];
    bus.en = 1'b0;
    bus.sync = 1'b0;
    bus.din = '0;

    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    // HUNT ignores unsynced slots
    repeat (4) slot(1'b0, W'(1));
    // aligned frame 0,1,0,1
    send_frame(W'(0), W'(1), W'(0), W'(1));
    idle(2);
    // same frame with a 3-cycle en gap between slots 1 and 2
    slot(1'b1, W'(0)); slot(1'b0, W'(1)); idle(3); slot(1'b0, W'(0)); slot(1'b0, W'(1));
`ifdef TDM_DEMUX_PARITY_EN
    slot(1'b0, W'(0));
`endif
    idle(2);
    // frame 1,1 then sync misplaced at slot 2, realigned frame 0,0,1,1
    slot(1'b1, W'(1)); slot(1'b0, W'(1));
    send_frame(W'(0), W'(0), W'(1), W'(1));
    idle(1);
    // missing sync at slot 0
    slot(1'b0, W'(5));
    idle(2);
    // reset mid-frame
    slot(1'b1, W'(3)); slot(1'b0, W'(7));
    step(1'b0, 1'b0, 1'b0, '0);
    idle(2);
`ifdef TDM_DEMUX_PARITY_EN
    // parity wrong then right for frame 1,0,1,1
    slot(1'b1, W'(1)); slot(1'b0, W'(0)); slot(1'b0, W'(1)); slot(1'b0, W'(1)); slot(1'b0, W'(0));
    slot(1'b1, W'(1)); slot(1'b0, W'(0)); slot(1'b0, W'(1)); slot(1'b0, W'(1)); slot(1'b0, W'(1));
    idle(1);
`endif

    // randomized frames with gaps, sync faults, parity faults and resets
    repeat (200) begin
      for (int i = 0; i < 4; i++) v[i] = W'($urandom);
      v[4] = ($urandom_range(0, 1) == 0) ? (v[0] ^ v[1] ^ v[2] ^ v[3]) : W'($urandom);
      for (int s = 0; s < NS; s++) begin
        bit sy;
        sy = (s == 0);
        if ($urandom_range(0, 24) == 0) sy = !sy;
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 99) == 0) step(1'b0, 1'b0, 1'b0, '0);
        slot(sy, v[s]);
      end
    end

    idle(4);
    while (evq.size() > 0) begin
      void'(evq.pop_front());
      flag("event_never_seen");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Receive-side 1:4 time-division demultiplexer. Takes a slot-serial stream built by a rotating 4:1 mux on the transmit side and aligns to a frame-sync marker. Each slot is steered into one of four channel registers, and all four channels are presented together with a one-cycle `valid` strobe per complete frame. It sits directly behind the link input and feeds per-channel consumers.

## Interface
- `WIDTH`, default 1: bits per slot and per channel output.
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `din` input WIDTH: slot data, sampled only when `en`=1.
- `en` input 1: slot strobe; one slot consumed per cycle with `en`=1.
- `sync` input 1: frame marker; qualified by `en`; marks slot 0.
- `a` output WIDTH: channel 0, slot 0.
- `b` output WIDTH: channel 1, slot 1.
- `c` output WIDTH: channel 2, slot 2.
- `d` output WIDTH: channel 3, slot 3.
- `valid` output 1: one-cycle pulse; `a`..`d` hold a new complete frame.
- `locked` output 1: 1 while in LOCKED state.
- `sync_err` output 1: one-cycle pulse on misaligned or missing sync.
- `par_err` output 1: only with `TDM_DEMUX_PARITY_EN`; one-cycle pulse alongside `valid`.

## Operation
- Reset (`rst_n`=0 at a clock edge) clears all of the following to 0: `a`, `b`, `c`, `d`, staging registers, `valid`, `locked`, `sync_err`, `par_err`, the slot counter, and the state register. The state resets to HUNT.
- FSM states: HUNT and LOCKED.
- HUNT:
  - `en`=1 with `sync`=0: sample discarded.
  - `en`=1 with `sync`=1: sample stored as slot 0, slot counter set to 1, move to LOCKED.
- LOCKED, on each `en`=1:
  - The sample is stored into the staging register for the current slot, and the counter advances.
  - The counter wraps from N-1 to 0, where N=4, or N=5 with parity.
- `en`=0: no state change. Staging, counter, and outputs hold.
- When the final slot (N-1) is sampled, all staging registers are copied to `a`..`d` on the same edge, and `valid` is high for the following cycle.
- Outputs hold between frames. Partial frames never reach the outputs.
- Misaligned sync: `en`=1 and `sync`=1 at a slot other than 0 while LOCKED.
  - `sync_err` pulses.
  - The partial frame is discarded.
  - The sample is taken as slot 0, the counter is set to 1, and the block stays LOCKED.
- Missing sync: `en`=1 and `sync`=0 at slot 0 while LOCKED.
  - `sync_err` pulses.
  - The sample is discarded and the block returns to HUNT with `locked`=0.
- Reset mid-frame: staging is abandoned, outputs clear to 0, and the block re-hunts.

## Timing
- Registered outputs only; no combinational path from any input to any output.
- Latency: `valid` and the new `a`..`d` appear 1 cycle after the edge that samples the final slot.
- Minimum frame period is N cycles with `en` held high, giving `valid` at most every N cycles.
- `locked` rises 1 cycle after the sync sample in HUNT. It falls 1 cycle after a missing-sync sample.
- `sync_err` is high exactly 1 cycle, the cycle after the offending sample.

## Configuration
- Macro: `TDM_DEMUX_PARITY_EN`.
- Defined:
  - Frame is 5 slots; slot 4 carries even parity, equal to a^b^c^d bitwise across WIDTH.
  - Slot 4 is checked on receipt. On mismatch, `par_err` pulses with `valid`; outputs are still updated.
  - The `par_err` port is present.
- Undefined: frame is 4 slots, no parity logic, and the `par_err` port is absent.

## Structure
- Package `tdm_demux_pkg` holds:
  - the state enum (HUNT, LOCKED);
  - the slot-count constants (4 or 5, chosen by the macro);
  - the slot-index width constant.
- One natural sub-module, `tdm_slot_ctr`: modulo-N counter with load-to-1, clear, and enable; reports whether it is at slot 0 and whether it is at the last slot.
- Staging registers, output registers, and the FSM live in the top level.

## Test plan
- Reset, then 4 `en` cycles with `sync`=0, `din`=1 → stays in HUNT; `locked`=0, `valid`=0, outputs stay 0.
- `sync` with slot 0, then `din` sequence 0,1,0,1 with `en` held high → `locked`=1; 1 cycle after slot 3: `a`=0, `b`=1, `c`=0, `d`=1, with `valid` high for one cycle.
- Same frame with `en` low for 3 cycles between slots 1 and 2 → identical outputs; `valid` delayed by exactly 3 cycles.
- Frame 1,1,0,0 then `sync` arriving at slot 2 → `sync_err` pulse, no `valid`, outputs keep the previous frame; realigned frame 0,0,1,1 → `c`=1, `d`=1, `valid`.
- LOCKED, then slot 0 arrives with `sync`=0 → `sync_err` pulse, `locked`=0 next cycle; `rst_n`=0 mid-frame → all outputs 0 next cycle.
- `TDM_DEMUX_PARITY_EN` defined, frame 1,0,1,1 with parity 0 → `valid` with `par_err`=1; repeat with parity 1 → `valid` with `par_err`=0.
